config_register_bank: RTL and testbench
=======================================

Name: config_register_bank

Overview:
Terminal consumer of one config slot's write and read channels from the global config block. Holds NUM_REGS software-writable registers, each with a valid flag, a one-cycle write strobe and a consume handshake. Answers AXI-lite-originated reads with single-outstanding, registered responses. Addresses on both channels are slot-local register indices.

Parameters:
NUM_REGS, 8, number of registers in this address space (≥1)
DATA_WIDTH, 64, register width; matches AXIL_DATA_BITS
ADDR_WIDTH, 8, width of incoming register index; must satisfy 2**ADDR_WIDTH ≥ NUM_REGS

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
wr_valid  in  1  write request, one cycle per write
wr_addr  in  ADDR_WIDTH  slot-local register index
wr_data  in  DATA_WIDTH  write data
rd_valid  in  1  read request valid
rd_addr  in  ADDR_WIDTH  slot-local register index
rd_ready  out  1  read request accepted when rd_valid && rd_ready
resp_valid  out  1  read response valid
resp_data  out  DATA_WIDTH  read data
resp_error  out  1  read targeted index ≥ NUM_REGS
resp_ready  in  1  response consumed when resp_valid && resp_ready
reg_data  out  NUM_REGS*DATA_WIDTH  register contents; reg i at [i*DATA_WIDTH +: DATA_WIDTH]
reg_valid  out  NUM_REGS  per-register "written, not yet consumed"
reg_wr_pulse  out  NUM_REGS  one-cycle strobe on the cycle after a write lands
reg_consume  in  NUM_REGS  per-register consume; clears reg_valid

Behaviour:
- Reset (async assert, sync deassert inside block via codebase reset resync):
  - reg_data = 0, reg_valid = 0, reg_wr_pulse = 0
  - resp_valid = 0, resp_data = 0, resp_error = 0
  - rd_ready = 1 once out of reset
- Write path, no backpressure:
  - If wr_valid and wr_addr < NUM_REGS, the next edge loads reg_data[wr_addr] = wr_data, sets reg_valid[wr_addr] = 1 and sets reg_wr_pulse[wr_addr] = 1 for exactly one cycle.
  - If wr_addr ≥ NUM_REGS, the write is silently dropped; no state change.
  - Back-to-back writes to the same index: each cycle overwrites the data. reg_wr_pulse stays high for each write cycle.
- Consume:
  - reg_consume[i] high at an edge clears reg_valid[i]. reg_data[i] is retained.
  - Same-edge write and consume of index i: write wins, so reg_valid[i] = 1 with the new data.
  - Consume of a register that is already invalid is a no-op.
- Read path, two states:
  - IDLE: rd_ready = 1. On rd_valid, capture at the edge and move to RESP.
    - Index < NUM_REGS: resp_data = reg_data[rd_addr] as it stood before that edge. A same-cycle write is not visible. resp_error = 0.
    - Index ≥ NUM_REGS: resp_data = 0, resp_error = 1.
    - resp_valid = 1 from the next cycle (latency 1).
  - RESP: rd_ready = 0; resp_valid, resp_data and resp_error are held stable. On resp_ready, resp_valid = 0 at the edge and return to IDLE.
  - A new request is not accepted in the same cycle the response retires. Maximum throughput is one read per 2 cycles.
  - Reads never affect reg_valid.
- Writes and reads are fully independent and may proceed concurrently.
- Reset mid-response: resp_valid drops asynchronously and the pending response is discarded. Upstream must not expect it.
- No X on any output after reset.

Test Plan:
- Reset, then wr_valid, wr_addr=3, wr_data=0xDEAD_BEEF -> next cycle reg_data[3]=0xDEADBEEF, reg_valid=8'b0000_1000, reg_wr_pulse[3] high for exactly 1 cycle.
- Write addr 8 with NUM_REGS=8 -> no register, valid or pulse change. Read addr 8 -> resp_valid=1 one cycle later, resp_error=1, resp_data=0.
- reg_consume[3] and a write to addr 3 (data 0x55) on the same edge -> reg_valid[3]=1, reg_data[3]=0x55. Consume alone next cycle -> reg_valid[3]=0, data remains 0x55.
- Read addr 2 (holds 0x11) while writing 0x22 to addr 2 on the same cycle -> response 0x11. A second read -> 0x22.
- Read accepted with resp_ready held low for 5 cycles -> resp_valid/resp_data stable, rd_ready=0 throughout. Raise resp_ready -> rd_ready=1 the following cycle.
- Assert rst_n=0 while resp_valid=1 -> resp_valid and all reg_valid fall without waiting for a clock edge. After release, a read of addr 0 returns 0.

Source files
------------

// File: rtl/config_register_bank.sv
// Config register bank: terminal consumer of one config slot's write and read channels.
// Holds NUM_REGS software-writable registers, each with a valid flag, a one-cycle write
// strobe and a consume handshake. Reads are single-outstanding with a registered response.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   wr_valid/wr_addr/wr_data    write channel (no backpressure, out-of-range dropped)
//   rd_valid/rd_addr/rd_ready   read request channel
//   resp_valid/resp_data/
//   resp_error/resp_ready       read response channel
//   reg_data                    flattened register contents, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//   reg_valid                   per-register "written, not yet consumed"
//   reg_wr_pulse                one-cycle strobe in the cycle after a write lands
//   reg_consume                 per-register consume, clears reg_valid
module config_register_bank #(
    parameter int unsigned NUM_REGS   = 8,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_valid,
    input  logic [ADDR_WIDTH-1:0]          wr_addr,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic                           rd_valid,
    input  logic [ADDR_WIDTH-1:0]          rd_addr,
    output logic                           rd_ready,
    output logic                           resp_valid,
    output logic [DATA_WIDTH-1:0]          resp_data,
    output logic                           resp_error,
    input  logic                           resp_ready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_data,
    output logic [NUM_REGS-1:0]            reg_valid,
    output logic [NUM_REGS-1:0]            reg_wr_pulse,
    input  logic [NUM_REGS-1:0]            reg_consume
);

    // Reset synchroniser: assertion is immediate, release is aligned to clk.
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    // ---------------------------------------------------------------------------------------
    // Write / consume path
    // ---------------------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] reg_data_q [NUM_REGS];
    logic [NUM_REGS-1:0]   reg_valid_q, reg_valid_d;
    logic [NUM_REGS-1:0]   reg_wr_pulse_q;
    logic [NUM_REGS-1:0]   wr_hit;

    // Out-of-range indices match no register, so such writes vanish without extra logic.
    always_comb begin
        wr_hit = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            wr_hit[i] = wr_valid && (32'(wr_addr) == i);
        end
    end

    // A write on the same edge as a consume wins.
    assign reg_valid_d = (reg_valid_q & ~reg_consume) | wr_hit;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                reg_data_q[i] <= '0;
            end
            reg_valid_q    <= '0;
            reg_wr_pulse_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (wr_hit[i]) begin
                    reg_data_q[i] <= wr_data;
                end
            end
            reg_valid_q    <= reg_valid_d;
            reg_wr_pulse_q <= wr_hit;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : gen_flat
        assign reg_data[g*DATA_WIDTH +: DATA_WIDTH] = reg_data_q[g];
    end

    assign reg_valid    = reg_valid_q;
    assign reg_wr_pulse = reg_wr_pulse_q;

    // ---------------------------------------------------------------------------------------
    // Read path
    // ---------------------------------------------------------------------------------------
    typedef enum logic {StIdle, StResp} rd_state_e;

    rd_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic                  resp_error_q, resp_error_d;
    logic [DATA_WIDTH-1:0] rd_sel_data;
    logic                  rd_in_range;

    // Samples pre-edge register contents, so a same-cycle write is not visible.
    always_comb begin
        rd_sel_data = '0;
        rd_in_range = 1'b0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (32'(rd_addr) == i) begin
                rd_sel_data = reg_data_q[i];
                rd_in_range = 1'b1;
            end
        end
    end

    // Held low during the reset window so nothing is accepted before the bank is live.
    assign rd_ready = (state_q == StIdle) && rst_int_n;

    always_comb begin
        state_d      = state_q;
        resp_data_d  = resp_data_q;
        resp_error_d = resp_error_q;
        unique case (state_q)
            StIdle: begin
                if (rd_valid && rd_ready) begin
                    state_d      = StResp;
                    resp_data_d  = rd_sel_data;
                    resp_error_d = !rd_in_range;
                end
            end
            StResp: begin
                // No new accept here: retiring and accepting never share a cycle.
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q      <= StIdle;
            resp_data_q  <= '0;
            resp_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            resp_data_q  <= resp_data_d;
            resp_error_q <= resp_error_d;
        end
    end

    assign resp_valid = (state_q == StResp);
    assign resp_data  = resp_data_q;
    assign resp_error = resp_error_q;

endmodule

// File: tb/tb_config_register_bank.sv
// Testbench for config_register_bank: directed vector table, randomized traffic against a
// behavioural model, and an asynchronous reset in the middle of a pending response.
module tb_config_register_bank;

    localparam int unsigned NR = 8;
    localparam int unsigned DW = 64;
    localparam int unsigned AW = 8;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 wr_valid;
    logic [AW-1:0]        wr_addr;
    logic [DW-1:0]        wr_data;
    logic                 rd_valid;
    logic [AW-1:0]        rd_addr;
    logic                 rd_ready;
    logic                 resp_valid;
    logic [DW-1:0]        resp_data;
    logic                 resp_error;
    logic                 resp_ready;
    logic [NR*DW-1:0]     reg_data;
    logic [NR-1:0]        reg_valid;
    logic [NR-1:0]        reg_wr_pulse;
    logic [NR-1:0]        reg_consume;

    config_register_bank #(
        .NUM_REGS  (NR),
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_valid    (wr_valid),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_valid    (rd_valid),
        .rd_addr     (rd_addr),
        .rd_ready    (rd_ready),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .resp_error  (resp_error),
        .resp_ready  (resp_ready),
        .reg_data    (reg_data),
        .reg_valid   (reg_valid),
        .reg_wr_pulse(reg_wr_pulse),
        .reg_consume (reg_consume)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model
    logic [DW-1:0] m_regs [NR];
    logic [NR-1:0] m_valid;
    logic [NR-1:0] m_pulse;
    bit            m_pending;
    logic [DW-1:0] m_rdata;
    logic          m_rerr;

    function automatic void model_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        m_valid   = '0;
        m_pulse   = '0;
        m_pending = 0;
        m_rdata   = '0;
        m_rerr    = 1'b0;
    endfunction

    // Applies one clock edge worth of rules to the model, using the inputs currently driven.
    function automatic void model_step();
        if (m_pending) begin
            if (resp_ready) m_pending = 0;
        end else if (rd_valid) begin
            m_pending = 1;
            m_rdata   = '0;
            m_rerr    = 1'b1;
            for (int i = 0; i < NR; i++) begin
                if (int'(rd_addr) == i) begin
                    m_rdata = m_regs[i];
                    m_rerr  = 1'b0;
                end
            end
        end
        m_pulse = '0;
        m_valid = m_valid & ~reg_consume;
        if (wr_valid) begin
            for (int i = 0; i < NR; i++) begin
                if (int'(wr_addr) == i) begin
                    m_regs[i]  = wr_data;
                    m_valid[i] = 1'b1;
                    m_pulse[i] = 1'b1;
                end
            end
        end
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        wr_valid    = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        rd_valid    = 1'b0;
        rd_addr     = '0;
        resp_ready  = 1'b0;
        reg_consume = '0;
    endtask

    // One clock: model follows the edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        for (int i = 0; i < NR; i++) begin
            chk($sformatf("%s reg_data[%0d]", tag, i), reg_data[i*DW +: DW], m_regs[i]);
        end
        chk({tag, " reg_valid"}, 64'(reg_valid), 64'(m_valid));
        chk({tag, " reg_wr_pulse"}, 64'(reg_wr_pulse), 64'(m_pulse));
        chk({tag, " resp_valid"}, 64'(resp_valid), 64'(m_pending));
        chk({tag, " rd_ready"}, 64'(rd_ready), 64'(!m_pending));
        if (m_pending) begin
            chk({tag, " resp_data"}, resp_data, m_rdata);
            chk({tag, " resp_error"}, 64'(resp_error), 64'(m_rerr));
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) tick();
    endtask

    typedef struct {
        logic          wv;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          rv;
        logic [AW-1:0] ra;
        logic          rr;
        logic [NR-1:0] cons;
        logic [NR-1:0] e_valid;
        logic [NR-1:0] e_pulse;
        logic          e_rvalid;
        logic [DW-1:0] e_rdata;
        logic          e_rerr;
        logic          e_rdy;
        int            e_idx;
        logic [DW-1:0] e_reg;
    } vec_t;

    function automatic vec_t mk(logic wv, logic [AW-1:0] wa, logic [DW-1:0] wd, logic rv,
                                logic [AW-1:0] ra, logic rr, logic [NR-1:0] cons,
                                logic [NR-1:0] ev, logic [NR-1:0] ep, logic erv,
                                logic [DW-1:0] erd, logic ere, logic erdy, int eidx,
                                logic [DW-1:0] ereg);
        vec_t v;
        v.wv = wv; v.wa = wa; v.wd = wd; v.rv = rv; v.ra = ra; v.rr = rr; v.cons = cons;
        v.e_valid = ev; v.e_pulse = ep; v.e_rvalid = erv; v.e_rdata = erd; v.e_rerr = ere;
        v.e_rdy = erdy; v.e_idx = eidx; v.e_reg = ereg;
        return v;
    endfunction

    vec_t vecs [19];

    initial begin
        //              wv wa wd                      rv ra rr cons   valid  pulse  rv data   er rdy idx reg
        vecs[0]  = mk(1, 3, 64'hDEAD_BEEF,            0, 0, 0, 8'h00, 8'h08, 8'h08, 0, 0,     0, 1, 3, 64'hDEAD_BEEF);
        vecs[1]  = mk(0, 0, 0,                        0, 0, 0, 8'h00, 8'h08, 8'h00, 0, 0,     0, 1, 3, 64'hDEAD_BEEF);
        vecs[2]  = mk(1, 8, 64'hFFFF_FFFF_FFFF_FFFF,  0, 0, 0, 8'h00, 8'h08, 8'h00, 0, 0,     0, 1, 0, 64'h0);
        vecs[3]  = mk(0, 0, 0,                        1, 8, 0, 8'h00, 8'h08, 8'h00, 1, 0,     1, 0, 3, 64'hDEAD_BEEF);
        vecs[4]  = mk(0, 0, 0,                        0, 0, 1, 8'h00, 8'h08, 8'h00, 0, 0,     0, 1, 3, 64'hDEAD_BEEF);
        vecs[5]  = mk(1, 3, 64'h55,                   0, 0, 0, 8'h08, 8'h08, 8'h08, 0, 0,     0, 1, 3, 64'h55);
        vecs[6]  = mk(0, 0, 0,                        0, 0, 0, 8'h08, 8'h00, 8'h00, 0, 0,     0, 1, 3, 64'h55);
        vecs[7]  = mk(1, 2, 64'h11,                   0, 0, 0, 8'h00, 8'h04, 8'h04, 0, 0,     0, 1, 2, 64'h11);
        vecs[8]  = mk(1, 2, 64'h22,                   1, 2, 0, 8'h00, 8'h04, 8'h04, 1, 64'h11, 0, 0, 2, 64'h22);
        vecs[9]  = mk(0, 0, 0,                        0, 0, 1, 8'h00, 8'h04, 8'h00, 0, 0,     0, 1, 2, 64'h22);
        vecs[10] = mk(0, 0, 0,                        1, 2, 0, 8'h00, 8'h04, 8'h00, 1, 64'h22, 0, 0, 2, 64'h22);
        vecs[11] = mk(0, 0, 0,                        1, 3, 1, 8'h00, 8'h04, 8'h00, 0, 0,     0, 1, 3, 64'h55);
        vecs[12] = mk(0, 0, 0,                        1, 3, 0, 8'h00, 8'h04, 8'h00, 1, 64'h55, 0, 0, 3, 64'h55);
        vecs[13] = mk(1, 3, 64'hAA,                   1, 0, 0, 8'h00, 8'h0C, 8'h08, 1, 64'h55, 0, 0, 3, 64'hAA);
        for (int i = 14; i < 18; i++) begin
            vecs[i] = mk(0, 0, 0,                     1, 0, 0, 8'h00, 8'h0C, 8'h00, 1, 64'h55, 0, 0, 3, 64'hAA);
        end
        vecs[18] = mk(0, 0, 0,                        0, 0, 1, 8'h00, 8'h0C, 8'h00, 0, 0,     0, 1, 3, 64'hAA);

        // Reset state
        do_reset();
        chk("reset reg_data", reg_data[DW-1:0] | reg_data[NR*DW-1:DW], 64'h0);
        chk("reset reg_valid", 64'(reg_valid), 64'h0);
        chk("reset reg_wr_pulse", 64'(reg_wr_pulse), 64'h0);
        chk("reset resp_valid", 64'(resp_valid), 64'h0);
        chk("reset resp_data", resp_data, 64'h0);
        chk("reset resp_error", 64'(resp_error), 64'h0);
        chk("reset rd_ready", 64'(rd_ready), 64'h1);

        // Directed vectors
        for (int n = 0; n < 19; n++) begin
            wr_valid    = vecs[n].wv;
            wr_addr     = vecs[n].wa;
            wr_data     = vecs[n].wd;
            rd_valid    = vecs[n].rv;
            rd_addr     = vecs[n].ra;
            resp_ready  = vecs[n].rr;
            reg_consume = vecs[n].cons;
            tick();
            chk($sformatf("vec%0d reg_valid", n), 64'(reg_valid), 64'(vecs[n].e_valid));
            chk($sformatf("vec%0d reg_wr_pulse", n), 64'(reg_wr_pulse), 64'(vecs[n].e_pulse));
            chk($sformatf("vec%0d resp_valid", n), 64'(resp_valid), 64'(vecs[n].e_rvalid));
            chk($sformatf("vec%0d rd_ready", n), 64'(rd_ready), 64'(vecs[n].e_rdy));
            chk($sformatf("vec%0d reg_data[%0d]", n, vecs[n].e_idx),
                reg_data[vecs[n].e_idx*DW +: DW], vecs[n].e_reg);
            if (vecs[n].e_rvalid) begin
                chk($sformatf("vec%0d resp_data", n), resp_data, vecs[n].e_rdata);
                chk($sformatf("vec%0d resp_error", n), 64'(resp_error), 64'(vecs[n].e_rerr));
            end
        end
        idle_inputs();
        tick();
        check_model("post-vec");

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            wr_valid    = ($urandom_range(0, 2) != 0);
            wr_addr     = AW'($urandom_range(0, 9));
            wr_data     = {$urandom, $urandom};
            rd_valid    = ($urandom_range(0, 1) != 0);
            rd_addr     = AW'($urandom_range(0, 9));
            resp_ready  = ($urandom_range(0, 2) == 0);
            reg_consume = NR'($urandom & $urandom);
            tick();
            check_model($sformatf("rand%0d", c));
        end

        // Reset while a response is pending: must drop without a clock edge
        idle_inputs();
        tick();
        wr_valid = 1'b1;
        wr_addr  = 0;
        wr_data  = 64'h1234_5678_9ABC_DEF0;
        rd_valid = 1'b1;
        rd_addr  = 1;
        tick();
        idle_inputs();
        chk("pre-reset resp_valid", 64'(resp_valid), 64'h1);
        chk("pre-reset reg_valid[0]", 64'(reg_valid[0]), 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset resp_valid", 64'(resp_valid), 64'h0);
        chk("async reset reg_valid", 64'(reg_valid), 64'h0);
        chk("async reset reg_data[0]", reg_data[DW-1:0], 64'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) tick();
        check_model("post-reset");
        rd_valid = 1'b1;
        rd_addr  = 0;
        tick();
        idle_inputs();
        chk("post-reset read resp_valid", 64'(resp_valid), 64'h1);
        chk("post-reset read resp_data", resp_data, 64'h0);
        chk("post-reset read resp_error", 64'(resp_error), 64'h0);
        resp_ready = 1'b1;
        tick();
        idle_inputs();
        check_model("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
